// File: rtl/mac_tx_axis_arbiter.sv
// mac_tx_axis_arbiter: packet-level N-channel AXI-Stream arbiter feeding one MAC TX port
// Ports:
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   s00_axis_*             N_CHANNELS packed AXIS slave channels (channel c at [c*W +: W])
//   m00_axis_*             merged AXIS master; tuser marks the forced-last beat of a truncated packet
//   o_grant                one-hot granted channel, zero while idle
//   o_truncate_count       saturating count of truncated packets
module mac_tx_axis_arbiter #(
    parameter int N_CHANNELS = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ARB_MODE   = 0,
    parameter int MAX_BEATS  = 0
) (
    input  logic                               i_clk,
    input  logic                               i_reset_n,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [N_CHANNELS*DATA_WIDTH/8-1:0] s00_axis_tkeep,
    input  logic [N_CHANNELS-1:0]              s00_axis_tvalid,
    input  logic [N_CHANNELS-1:0]              s00_axis_tlast,
    output logic [N_CHANNELS-1:0]              s00_axis_tready,
    output logic [DATA_WIDTH-1:0]              m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]            m00_axis_tkeep,
    output logic                               m00_axis_tvalid,
    output logic                               m00_axis_tlast,
    output logic                               m00_axis_tuser,
    input  logic                               m00_axis_tready,
    output logic [N_CHANNELS-1:0]              o_grant,
    output logic [15:0]                        o_truncate_count
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int IW = $clog2(N_CHANNELS);

    typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [N_CHANNELS-1:0] grant_q, grant_d;
    logic [IW-1:0]         gidx_q, gidx_d, rr_q, rr_d, win_idx, cand, rr_next;
    logic [15:0]           beat_q, beat_d, trunc_q, trunc_d;
    logic                  win_ok, g_valid, g_last, pass, drain, hs, trunc_beat;

    // Search starts at the RR pointer in round-robin mode, at channel 0 in fixed-priority mode
    always_comb begin
        win_idx = '0;
        win_ok  = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            cand = (ARB_MODE != 0) ? IW'(k) : IW'((int'(rr_q) + k) % N_CHANNELS);
            if (!win_ok && s00_axis_tvalid[cand]) begin
                win_idx = cand;
                win_ok  = 1'b1;
            end
        end
    end

    assign pass       = state_q == PASS;
    assign drain      = state_q == DRAIN;
    assign g_valid    = s00_axis_tvalid[gidx_q];
    assign g_last     = s00_axis_tlast[gidx_q];
    assign hs         = pass && g_valid && m00_axis_tready;
    // A source ending exactly on the limit beat is a normal end, not a truncation
    assign trunc_beat = (MAX_BEATS != 0) && (beat_q == 16'(MAX_BEATS - 1)) && !g_last;
    assign rr_next    = (gidx_q == IW'(N_CHANNELS - 1)) ? '0 : gidx_q + 1'b1;

    assign m00_axis_tdata   = s00_axis_tdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign m00_axis_tkeep   = s00_axis_tkeep[int'(gidx_q)*KW +: KW];
    assign m00_axis_tvalid  = pass && g_valid;
    assign m00_axis_tlast   = pass && (g_last || trunc_beat);
    assign m00_axis_tuser   = pass && trunc_beat;
    assign s00_axis_tready  = grant_q & {N_CHANNELS{(pass && m00_axis_tready) || drain}};
    assign o_grant          = grant_q;
    assign o_truncate_count = trunc_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        trunc_d = trunc_q;
        if (state_q == IDLE) begin
            if (win_ok) begin
                state_d = PASS;
                grant_d = {{(N_CHANNELS-1){1'b0}}, 1'b1} << win_idx;
                gidx_d  = win_idx;
                beat_d  = '0;
            end
        end else if (pass) begin
            if (hs) begin
                beat_d = beat_q + 16'd1;
                if (g_last || trunc_beat) begin
                    rr_d    = rr_next;
                    state_d = trunc_beat ? DRAIN : IDLE;
                    grant_d = trunc_beat ? grant_q : '0;
                    trunc_d = !trunc_beat ? trunc_q : (trunc_q == 16'hFFFF) ? trunc_q : trunc_q + 16'd1;
                end
            end
        end else if (g_valid && g_last) begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            trunc_q <= trunc_d;
        end
    end
endmodule

// File: tb/tb_mac_tx_axis_arbiter.sv
// tb_mac_tx_axis_arbiter: randomized scoreboard bench for the TX AXIS arbiter
module tb_mac_tx_axis_arbiter;
    localparam int N    = 4;
    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int MB   = 4;
    localparam int NPKT = 12;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          go = 1'b0, mon_en = 1'b0, rand_rdy = 1'b0, dir = 1'b1, fp_done = 1'b0;
    logic [N-1:0]  dir_valid = '0, dir_last = '0, done;
    logic [DW-1:0] dir_data = 64'h0123_4567_89ab_cdef;

    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready, grant;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid, m_tlast, m_tuser, m_tready;
    logic [15:0]     tcnt;

    logic [DW-1:0]   fd1, fd3;
    logic            fl1, fl3;
    logic [N-1:0]    f_tvalid, f_tready, f_grant;
    logic [DW-1:0]   f_mdata;
    logic [KW-1:0]   f_mkeep;
    logic            f_mvalid, f_mlast, f_muser;
    logic [15:0]     f_tcnt;

    int    tests = 0, fails = 0, exp_trunc = 0;
    beat_t exp_q[N][$];

    mac_tx_axis_arbiter #(.N_CHANNELS(N), .DATA_WIDTH(DW), .ARB_MODE(0), .MAX_BEATS(MB)) u_rr (
        .i_clk(clk), .i_reset_n(rst_n),
        .s00_axis_tdata(s_tdata), .s00_axis_tkeep(s_tkeep), .s00_axis_tvalid(s_tvalid),
        .s00_axis_tlast(s_tlast), .s00_axis_tready(s_tready),
        .m00_axis_tdata(m_tdata), .m00_axis_tkeep(m_tkeep), .m00_axis_tvalid(m_tvalid),
        .m00_axis_tlast(m_tlast), .m00_axis_tuser(m_tuser), .m00_axis_tready(m_tready),
        .o_grant(grant), .o_truncate_count(tcnt)
    );

    mac_tx_axis_arbiter #(.N_CHANNELS(N), .DATA_WIDTH(DW), .ARB_MODE(1), .MAX_BEATS(0)) u_fp (
        .i_clk(clk), .i_reset_n(rst_n),
        .s00_axis_tdata({fd3, 64'h0, fd1, 64'h0}), .s00_axis_tkeep('1), .s00_axis_tvalid(f_tvalid),
        .s00_axis_tlast({fl3, 1'b0, fl1, 1'b0}), .s00_axis_tready(f_tready),
        .m00_axis_tdata(f_mdata), .m00_axis_tkeep(f_mkeep), .m00_axis_tvalid(f_mvalid),
        .m00_axis_tlast(f_mlast), .m00_axis_tuser(f_muser), .m00_axis_tready(1'b1),
        .o_grant(f_grant), .o_truncate_count(f_tcnt)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
        end
    endtask

    task automatic fail1(input string n);
        tests++;
        fails++;
        $display("FAIL %s: got timeout/unexpected event expected normal progress at %0t", n, $time);
    endtask

    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_ch
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          valid, last, fin;
        assign s_tdata[c*DW +: DW] = dir ? dir_data : data;
        assign s_tkeep[c*KW +: KW] = dir ? '1 : keep;
        assign s_tvalid[c]         = dir ? dir_valid[c] : valid;
        assign s_tlast[c]          = dir ? dir_last[c] : last;
        assign done[c]             = fin;
        initial begin : drv
            int            len, gap, t;
            logic [DW-1:0] pd[8];
            logic [KW-1:0] pk[8];
            beat_t         e;
            data = '0; keep = '0; valid = 1'b0; last = 1'b0; fin = 1'b0;
            wait (go);
            for (int p = 0; p < NPKT; p++) begin
                len = $urandom_range(1, 7);
                for (int b = 0; b < len; b++) begin
                    pd[b] = {$urandom, $urandom};
                    pk[b] = KW'($urandom);
                    if (b < MB) begin
                        e.d = pd[b];
                        e.k = pk[b];
                        e.u = (b == MB - 1) && (len > MB);
                        e.l = (b == len - 1) || e.u;
                        exp_q[c].push_back(e);
                    end
                end
                for (int b = 0; b < len; b++) begin
                    gap = $urandom_range(0, 2);
                    valid = 1'b0;
                    repeat (gap) begin @(posedge clk); #1; end
                    data = pd[b]; keep = pk[b]; last = (b == len - 1); valid = 1'b1;
                    t = 0;
                    do begin @(negedge clk); t++; end while (!s_tready[c] && t < 2000);
                    if (!s_tready[c]) fail1("source_handshake");
                    @(posedge clk);
                    #1;
                end
            end
            valid = 1'b0; last = 1'b0; fin = 1'b1;
        end
    end

    // Reference view: a grant is decided from the requests seen during the idle cycle,
    // round-robin from the channel after the last one served; packets come out whole,
    // cut at MB beats with the cut beat flagged.
    initial begin : mon
        logic [N-1:0] pv, mg;
        int           cur, w, rr_m;
        bit           endp, drn;
        beat_t        e;
        pv = '0; mg = '0; cur = 0; rr_m = 0; endp = 0; drn = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("trunc_count", tcnt, exp_trunc);
                if (mg == 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && pv[(rr_m + k) % N]) w = (rr_m + k) % N;
                    if (w >= 0) begin
                        mg = N'(1) << w;
                        cur = w;
                        rr_m = (w + 1) % N;
                        drn = 0;
                    end
                end else if (endp) mg = '0;
                endp = 0;
                chk("grant", grant, mg);
                if (mg == 0) begin
                    chk("idle_tvalid", m_tvalid, 0);
                    chk("idle_tready", s_tready, 0);
                end else if (drn) begin
                    chk("drain_tvalid", m_tvalid, 0);
                    chk("drain_tready", s_tready, mg);
                    if (s_tvalid[cur] && s_tlast[cur]) endp = 1;
                end else begin
                    chk("pass_tready", s_tready, m_tready ? mg : '0);
                    chk("pass_tvalid", m_tvalid, s_tvalid[cur]);
                    if (m_tvalid && m_tready) begin
                        if (exp_q[cur].size() == 0) fail1("unexpected_beat");
                        else begin
                            e = exp_q[cur].pop_front();
                            chk("beat_data", m_tdata, e.d);
                            chk("beat_keep", m_tkeep, e.k);
                            chk("beat_last", m_tlast, e.l);
                            chk("beat_user", m_tuser, e.u);
                            if (e.u) begin exp_trunc++; drn = 1; end
                            else if (e.l) endp = 1;
                        end
                    end
                end
                pv = s_tvalid;
            end
        end
    end

    initial begin : fpdrv
        logic h;
        fd1 = {$urandom, $urandom}; fl1 = 1'b0;
        fd3 = {$urandom, $urandom}; fl3 = 1'b1;
        f_tvalid = 4'b1010;
        forever begin
            @(negedge clk);
            h = f_tready[1];
            @(posedge clk);
            #1;
            if (h) begin
                fd1 = {$urandom, $urandom};
                fl1 = ($urandom_range(0, 2) == 0);
            end
        end
    end

    // Fixed priority with channels 1 and 3 always requesting: channel 1 wins every time
    initial begin : fpmon
        logic [N-1:0] fg;
        fg = '0;
        wait (go);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("fp_grant", f_grant, fg);
            chk("fp_ch3_ready", f_tready[3], 0);
            if (fg != 0) begin
                chk("fp_tvalid", f_mvalid, 1);
                chk("fp_tdata", f_mdata, fd1);
                chk("fp_tlast", f_mlast, fl1);
                chk("fp_tuser", f_muser, 0);
            end
            fg = (fg == 0) ? 4'b0010 : (fl1 ? 4'b0000 : 4'b0010);
        end
        fp_done = 1'b1;
    end

    initial begin : main
        int t;
        dir_valid = 4'b0101;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tuser", m_tuser, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_count", tcnt, 0);
        chk("rst_fp_tready", f_tready, 0);
        @(posedge clk);
        #1;
        dir = 1'b0; dir_valid = '0; rst_n = 1'b1; go = 1'b1; mon_en = 1'b1; rand_rdy = 1'b1;
        t = 0;
        while (!(&done && fp_done) && t < 20000) begin @(posedge clk); t++; end
        if (!(&done && fp_done)) fail1("random_phase_done");
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0; rand_rdy = 1'b0;
        for (int c = 0; c < N; c++) chk("queue_empty", exp_q[c].size(), 0);
        chk("final_trunc_count", tcnt, exp_trunc);
        repeat (2) @(posedge clk);
        #1;
        dir = 1'b1; dir_valid = 4'b0001; dir_last = 4'b0001;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_tready[0] && t < 50);
        if (!s_tready[0]) fail1("dir_ch0_handshake");
        @(posedge clk);
        #1;
        dir_valid = 4'b0101; dir_last = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rr_after_ch0", grant, 4'b0100);
        repeat (2) @(negedge clk);
        chk("beat2_grant", grant, 4'b0100);
        chk("beat2_tvalid", m_tvalid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", grant, 0);
        chk("async_rst_tvalid", m_tvalid, 0);
        chk("async_rst_tready", s_tready, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("restart_ch0", grant, 4'b0001);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
